// File: rtl/tawas_ls_pkg.sv
// Shared types and lane helpers for the tawas load/store pipe.
// Size encodings, load-queue entry metadata, byte-lane mask/replicate/extract functions.
package tawas_ls_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } ls_size_e;

    // Per-load metadata kept until the response returns; the destination register is appended.
    typedef struct packed {
        ls_size_e   size;
        logic       sgn;
        logic [1:0] lane;
    } ls_meta_t;

    localparam int unsigned LS_META_W = $bits(ls_meta_t);

    function automatic logic [3:0] ls_lane_mask(ls_size_e size, logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            LS_BYTE: mask = 4'b0001 << lane;
            LS_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] ls_lane_data(ls_size_e size, logic [31:0] wd);
        logic [31:0] data;
        case (size)
            LS_BYTE: data = {4{wd[7:0]}};
            LS_HALF: data = {2{wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] ls_extract(ls_meta_t meta, logic [31:0] din);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = din >> {meta.lane, 3'b000};
        half    = meta.lane[1] ? din[31:16] : din[15:0];
        case (meta.size)
            LS_BYTE: res = {{24{meta.sgn & shifted[7]}}, shifted[7:0]};
            LS_HALF: res = {{16{meta.sgn & half[15]}}, half};
            default: res = din;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tawas_ls_fifo.sv
// Synchronous FIFO holding outstanding-load entries, with occupancy count.
// The caller never pushes when full nor pops when empty.
module tawas_ls_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/tawas_ls_pipe.sv
// Load/store unit: req/gnt data bus, in-order load responses, pointer writeback.
// Optional misaligned-access trap when TAWAS_LS_ALIGN_CHK_EN is defined.
module tawas_ls_pipe
    import tawas_ls_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_op_vld,
    output logic              o_op_rdy,
    input  logic              i_op_store,
    input  logic [1:0]        i_op_size,
    input  logic              i_op_signed,
    input  logic [ADDR_W-1:0] i_op_ptr,
    input  logic [ADDR_W-1:0] i_op_ofs,
    input  logic              i_op_pre,
    input  logic              i_op_upd,
    input  logic [SEL_W-1:0]  i_op_ptr_sel,
    input  logic [SEL_W-1:0]  i_op_reg,
    input  logic [31:0]       i_op_wdata,
    output logic              o_dreq,
    input  logic              i_dgnt,
    output logic              o_dwr,
    output logic [ADDR_W-1:0] o_daddr,
    output logic [3:0]        o_dmask,
    output logic [31:0]       o_dout,
    input  logic              i_drsp_vld,
    input  logic [31:0]       i_din,
    output logic              o_ptr_upd_vld,
    output logic [SEL_W-1:0]  o_ptr_upd_sel,
    output logic [ADDR_W-1:0] o_ptr_upd,
    output logic              o_ls_load_vld,
    output logic [SEL_W-1:0]  o_ls_load_sel,
    output logic [31:0]       o_ls_load,
    output logic              o_ls_err
`ifdef TAWAS_LS_ALIGN_CHK_EN
    ,
    output logic              o_ls_align_fault
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = LS_META_W + SEL_W;

    logic [ADDR_W-1:0] w_ptr_sum;
    logic [ADDR_W-1:0] w_addr;
    ls_size_e          w_size;
    ls_meta_t          w_meta;
    ls_meta_t          w_head_meta;
    logic [ENT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_ld_cnt;
    logic              w_accept;
    logic              w_misal;
    logic              w_issue;
    logic              w_push;
    logic              w_rsp_ok;

    logic              r_dreq;
    logic              r_dwr;
    logic [ADDR_W-1:0] r_daddr;
    logic [3:0]        r_dmask;
    logic [31:0]       r_dout;
    logic              r_ptr_upd_vld;
    logic [SEL_W-1:0]  r_ptr_upd_sel;
    logic [ADDR_W-1:0] r_ptr_upd;
    logic              r_ls_load_vld;
    logic [SEL_W-1:0]  r_ls_load_sel;
    logic [31:0]       r_ls_load;
    logic              r_ls_err;

    assign w_ptr_sum = i_op_ptr + i_op_ofs;
    assign w_addr    = i_op_pre ? w_ptr_sum : i_op_ptr;
    assign w_size    = ls_size_e'(i_op_size);
    assign o_op_rdy  = (!r_dreq || i_dgnt) && (w_ld_cnt < CNT_W'(DEPTH));
    assign w_accept  = i_op_vld && o_op_rdy;

`ifdef TAWAS_LS_ALIGN_CHK_EN
    assign w_misal = ((w_size == LS_HALF) && w_addr[0]) ||
                     ((w_size inside {LS_WORD, LS_RSVD}) && (w_addr[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    // A trapped access is still accepted but never reaches the bus or the queue.
    assign w_issue  = w_accept && !w_misal;
    assign w_push   = w_issue && !i_op_store;
    assign w_rsp_ok = i_drsp_vld && (w_ld_cnt != '0);

    always_comb begin
        w_meta      = '0;
        w_meta.size = w_size;
        w_meta.sgn  = i_op_signed;
        w_meta.lane = w_addr[1:0];
    end

    assign w_head_meta = ls_meta_t'(w_head[ENT_W-1:SEL_W]);

    tawas_ls_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_rsp_ok),
        .i_wdata ({w_meta, i_op_reg}),
        .o_rdata (w_head),
        .o_count (w_ld_cnt)
    );

    // Request qualifiers only change on issue, so they stay put while waiting for grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dreq  <= 1'b0;
            r_dwr   <= 1'b0;
            r_daddr <= '0;
            r_dmask <= '0;
            r_dout  <= '0;
        end else if (w_issue) begin
            r_dreq  <= 1'b1;
            r_dwr   <= i_op_store;
            r_daddr <= {w_addr[ADDR_W-1:2], 2'b00};
            r_dmask <= ls_lane_mask(w_size, w_addr[1:0]);
            r_dout  <= i_op_store ? ls_lane_data(w_size, i_op_wdata) : 32'h0;
        end else if (i_dgnt) begin
            r_dreq  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr_upd_vld <= 1'b0;
            r_ptr_upd_sel <= '0;
            r_ptr_upd     <= '0;
        end else begin
            r_ptr_upd_vld <= w_accept && i_op_upd;
            if (w_accept && i_op_upd) begin
                r_ptr_upd_sel <= i_op_ptr_sel;
                r_ptr_upd     <= w_ptr_sum;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ls_load_vld <= 1'b0;
            r_ls_load_sel <= '0;
            r_ls_load     <= '0;
            r_ls_err      <= 1'b0;
        end else begin
            r_ls_load_vld <= w_rsp_ok;
            if (w_rsp_ok) begin
                r_ls_load_sel <= w_head[SEL_W-1:0];
                r_ls_load     <= ls_extract(w_head_meta, i_din);
            end
            if (i_drsp_vld && !w_rsp_ok) r_ls_err <= 1'b1;
        end
    end

`ifdef TAWAS_LS_ALIGN_CHK_EN
    logic r_align_fault;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_align_fault <= 1'b0;
        else       r_align_fault <= w_accept && w_misal;
    end

    assign o_ls_align_fault = r_align_fault;
`endif

    assign o_dreq        = r_dreq;
    assign o_dwr         = r_dwr;
    assign o_daddr       = r_daddr;
    assign o_dmask       = r_dmask;
    assign o_dout        = r_dout;
    assign o_ptr_upd_vld = r_ptr_upd_vld;
    assign o_ptr_upd_sel = r_ptr_upd_sel;
    assign o_ptr_upd     = r_ptr_upd;
    assign o_ls_load_vld = r_ls_load_vld;
    assign o_ls_load_sel = r_ls_load_sel;
    assign o_ls_load     = r_ls_load;
    assign o_ls_err      = r_ls_err;

endmodule

// File: tb/tb_tawas_ls_pipe.sv
// Self-checking bench for tawas_ls_pipe: directed scenarios plus a randomized phase,
// both compared against a cycle-level behavioural model built on a queue of pending loads.
module tb_tawas_ls_pipe;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_vld, op_rdy, op_store, op_signed, op_pre, op_upd;
    logic [1:0]  op_size;
    logic [31:0] op_ptr, op_ofs, op_wdata;
    logic [2:0]  op_ptr_sel, op_reg;
    logic        dreq, dgnt, dwr, drsp_vld;
    logic [31:0] daddr, dout, din;
    logic [3:0]  dmask;
    logic        ptr_upd_vld, ls_load_vld, ls_err;
    logic [2:0]  ptr_upd_sel, ls_load_sel;
    logic [31:0] ptr_upd, ls_load;
    logic        align_fault;

    tawas_ls_pipe #(
        .ADDR_W (32),
        .SEL_W  (3),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_op_vld      (op_vld),
        .o_op_rdy      (op_rdy),
        .i_op_store    (op_store),
        .i_op_size     (op_size),
        .i_op_signed   (op_signed),
        .i_op_ptr      (op_ptr),
        .i_op_ofs      (op_ofs),
        .i_op_pre      (op_pre),
        .i_op_upd      (op_upd),
        .i_op_ptr_sel  (op_ptr_sel),
        .i_op_reg      (op_reg),
        .i_op_wdata    (op_wdata),
        .o_dreq        (dreq),
        .i_dgnt        (dgnt),
        .o_dwr         (dwr),
        .o_daddr       (daddr),
        .o_dmask       (dmask),
        .o_dout        (dout),
        .i_drsp_vld    (drsp_vld),
        .i_din         (din),
        .o_ptr_upd_vld (ptr_upd_vld),
        .o_ptr_upd_sel (ptr_upd_sel),
        .o_ptr_upd     (ptr_upd),
        .o_ls_load_vld (ls_load_vld),
        .o_ls_load_sel (ls_load_sel),
        .o_ls_load     (ls_load),
        .o_ls_err      (ls_err)
`ifdef TAWAS_LS_ALIGN_CHK_EN
        ,
        .o_ls_align_fault (align_fault)
`endif
    );

`ifndef TAWAS_LS_ALIGN_CHK_EN
    assign align_fault = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] size;
        logic       sgn;
        logic [1:0] lo;
        logic [2:0] rd;
    } pend_t;

    pend_t       q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        m_dreq, m_dwr, m_pv, m_lv, m_err, m_af;
    logic [31:0] m_daddr, m_dout, m_p, m_l;
    logic [3:0]  m_dmask;
    logic [2:0]  m_ps, m_ls;

    function automatic logic [3:0] ref_mask(logic [1:0] size, logic [1:0] lo);
        if (size == 2'd0) return 4'(1 << lo);
        if (size == 2'd1) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [1:0] size, logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(pend_t p, logic [31:0] d);
        int          w;
        int          sh;
        logic [31:0] v;
        logic [31:0] lim;
        w  = (p.size == 2'd0) ? 8 : (p.size == 2'd1) ? 16 : 32;
        sh = (p.size == 2'd0) ? int'(p.lo) * 8 : (p.size == 2'd1) ? (int'(p.lo) / 2) * 16 : 0;
        v  = d >> sh;
        if (w < 32) begin
            lim = (32'h1 << w) - 32'h1;
            v   = v & lim;
            if (p.sgn && v[w-1]) v = v | ~lim;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_rdy();
        return (!m_dreq || dgnt) && (q.size() < DEPTH);
    endfunction

    task automatic check_model();
        chk("op_rdy", op_rdy, ref_rdy());
        chk("dreq", dreq, m_dreq);
        if (m_dreq) begin
            chk("dwr", dwr, m_dwr);
            chk("daddr", daddr, m_daddr);
            chk("dmask", dmask, m_dmask);
            chk("dout", dout, m_dout);
        end
        chk("ptr_upd_vld", ptr_upd_vld, m_pv);
        if (m_pv) begin
            chk("ptr_upd_sel", ptr_upd_sel, m_ps);
            chk("ptr_upd", ptr_upd, m_p);
        end
        chk("ls_load_vld", ls_load_vld, m_lv);
        if (m_lv) begin
            chk("ls_load_sel", ls_load_sel, m_ls);
            chk("ls_load", ls_load, m_l);
        end
        chk("ls_err", ls_err, m_err);
`ifdef TAWAS_LS_ALIGN_CHK_EN
        chk("align_fault", align_fault, m_af);
`endif
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        logic        acc;
        logic        mis;
        logic [31:0] addr;
        pend_t       p;
        acc  = op_vld && ref_rdy();
        addr = op_pre ? op_ptr + op_ofs : op_ptr;
        mis  = 1'b0;
`ifdef TAWAS_LS_ALIGN_CHK_EN
        mis = (op_size == 2'd1 && addr[0]) || (op_size >= 2'd2 && addr[1:0] != 2'd0);
`endif
        m_af = acc && mis;
        m_lv = 1'b0;
        if (drsp_vld) begin
            if (q.size() > 0) begin
                p    = q.pop_front();
                m_lv = 1'b1;
                m_ls = p.rd;
                m_l  = ref_load(p, din);
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc && !mis) begin
            m_dreq  = 1'b1;
            m_dwr   = op_store;
            m_daddr = addr & ~32'h3;
            m_dmask = ref_mask(op_size, addr[1:0]);
            m_dout  = op_store ? ref_wdata(op_size, op_wdata) : 32'h0;
            if (!op_store) q.push_back('{size: op_size, sgn: op_signed, lo: addr[1:0], rd: op_reg});
        end else if (dgnt) begin
            m_dreq = 1'b0;
        end
        m_pv = acc && op_upd;
        if (m_pv) begin
            m_p  = op_ptr + op_ofs;
            m_ps = op_ptr_sel;
        end
    endtask

    // Called at posedge+1; checks mid-cycle, then returns at the next posedge+1.
    task automatic tick();
        #4;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_vld = 0; op_store = 0; op_size = 0; op_signed = 0; op_ptr = 0; op_ofs = 0;
        op_pre = 0; op_upd = 0; op_ptr_sel = 0; op_reg = 0; op_wdata = 0;
        dgnt = 0; drsp_vld = 0; din = 0;
    endtask

    task automatic set_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ptr, input logic [31:0] ofs, input logic pre,
                          input logic upd, input logic [2:0] rd, input logic [31:0] wd);
        op_vld = 1; op_store = st; op_size = sz; op_signed = sg; op_ptr = ptr; op_ofs = ofs;
        op_pre = pre; op_upd = upd; op_ptr_sel = rd + 3'd1; op_reg = rd; op_wdata = wd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #4;
        chk("rst_op_rdy", op_rdy, 1);
        chk("rst_dreq", dreq, 0);
        chk("rst_dwr", dwr, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dmask", dmask, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ptr_vld", ptr_upd_vld, 0);
        chk("rst_ptr", ptr_upd, 0);
        chk("rst_load_vld", ls_load_vld, 0);
        chk("rst_load", ls_load, 0);
        chk("rst_err", ls_err, 0);
        chk("rst_align", align_fault, 0);
        m_dreq = 0; m_dwr = 0; m_daddr = 0; m_dmask = 0; m_dout = 0; m_pv = 0; m_ps = 0;
        m_p = 0; m_lv = 0; m_ls = 0; m_l = 0; m_err = 0; m_af = 0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // Word store with pre-increment and pointer writeback.
        set_op(1, 2'd2, 0, 32'h100, 32'h4, 1, 1, 3'd4, 32'hDEADBEEF);
        dgnt = 1;
        tick();
        op_vld = 0;
        chk("st_dreq", dreq, 1);
        chk("st_dwr", dwr, 1);
        chk("st_daddr", daddr, 32'h104);
        chk("st_dmask", dmask, 4'hF);
        chk("st_ptr_upd", ptr_upd, 32'h104);
        tick();

        // Signed byte load from lane 3.
        set_op(0, 2'd0, 1, 32'h203, 32'h0, 0, 0, 3'd6, 32'h0);
        tick();
        op_vld = 0;
        chk("ldb_daddr", daddr, 32'h200);
        chk("ldb_dmask", dmask, 4'b1000);
        tick();
        drsp_vld = 1; din = 32'h80123456;
        tick();
        drsp_vld = 0;
        chk("ldb_vld", ls_load_vld, 1);
        chk("ldb_val", ls_load, 32'hFFFFFF80);
        chk("ldb_sel", ls_load_sel, 3'd6);
        tick();

        // Grant withheld for three cycles while a second operation waits.
        dgnt = 0;
        set_op(1, 2'd2, 0, 32'h300, 32'h0, 0, 0, 3'd1, 32'h11223344);
        tick();
        set_op(0, 2'd1, 0, 32'h402, 32'h0, 0, 0, 3'd2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", op_rdy, 0);
            chk("stall_daddr", daddr, 32'h300);
            tick();
        end
        dgnt = 1;
        tick();
        op_vld = 0;
        chk("unstall_daddr", daddr, 32'h400);
        chk("unstall_dmask", dmask, 4'b1100);
        tick();
        drsp_vld = 1; din = 32'hABCD1234;
        tick();
        drsp_vld = 0;
        chk("ldh_val", ls_load, 32'h0000ABCD);
        tick();

        // Fill the load queue, then overlap a response with a new accept.
        for (int i = 0; i < DEPTH; i++) begin
            set_op(0, 2'd2, 0, 32'h500 + 32'(i * 4), 32'h0, 0, 0, 3'(i), 32'h0);
            tick();
        end
        set_op(0, 2'd1, 1, 32'h600, 32'h0, 0, 0, 3'd5, 32'h0);
        #1;
        chk("full_rdy", op_rdy, 0);
        tick();
        drsp_vld = 1; din = $urandom;
        tick();
        din = $urandom;
        tick();
        drsp_vld = 0;
        set_op(0, 2'd0, 0, 32'h701, 32'h0, 0, 0, 3'd7, 32'h0);
        #1;
        chk("refill_rdy", op_rdy, 1);
        tick();
        op_vld = 0;
        chk("refull_rdy", op_rdy, 0);
        drsp_vld = 1;
        for (int i = 0; i < DEPTH; i++) begin
            din = $urandom;
            tick();
        end

        // Response with nothing outstanding.
        din = 32'h12345678;
        tick();
        drsp_vld = 0;
        chk("spur_vld", ls_load_vld, 0);
        chk("spur_err", ls_err, 1);
        tick();
        tick();
        chk("err_sticky", ls_err, 1);
        do_reset();

        // Randomized traffic with stalls and responses.
        for (int c = 0; c < 800; c++) begin
            set_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                   32'($urandom_range(0, 16)) - 32'd8, 1'($urandom), 1'($urandom),
                   3'($urandom), $urandom);
            op_vld   = 1'($urandom_range(0, 2) != 0);
            dgnt     = 1'($urandom_range(0, 3) != 0);
            drsp_vld = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            din      = $urandom;
            tick();
        end

        // Reset with loads in flight must drop them.
        idle();
        dgnt = 1;
        set_op(0, 2'd2, 0, 32'h800, 32'h0, 0, 0, 3'd3, 32'h0);
        tick();
        tick();
        do_reset();
        drsp_vld = 1; din = 32'h55AA55AA;
        tick();
        drsp_vld = 0;
        chk("rst_drop_vld", ls_load_vld, 0);
        chk("rst_drop_err", ls_err, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
